// File: rtl/instr_register_pipe_if.sv
// Bus bundle for instr_register_pipe: load handshake, read port, flush control and status.
// Handshake: a load transfers on a posedge where load_en && load_rdy; load_en may rise
// at any time, and every load field must hold steady while load_en is high.
interface instr_register_pipe_if #(
  parameter int OP_WIDTH  = 32,
  parameter int DEPTH     = 32,
  parameter int RES_WIDTH = 2*OP_WIDTH,
  parameter int AW        = $clog2(DEPTH)
);
  localparam int W = 3 + 2*OP_WIDTH + RES_WIDTH + 1;

  logic                 load_en;
  logic                 load_rdy;
  logic [2:0]           opcode;
  logic [OP_WIDTH-1:0]  operand_a;
  logic [OP_WIDTH-1:0]  operand_b;
  logic                 auto_inc;
  logic [AW-1:0]        write_pointer;
  logic                 read_en;
  logic [AW-1:0]        read_pointer;
  logic                 flush;
  logic [W-1:0]         instruction_word;
  logic                 instr_valid;
  logic [AW-1:0]        wr_count;
  logic                 div_zero_err;
  logic                 busy;
  logic [1:0]           state_dbg;

  modport master (
    output load_en, opcode, operand_a, operand_b, auto_inc, write_pointer,
           read_en, read_pointer, flush,
    input  load_rdy, instruction_word, instr_valid, wr_count, div_zero_err, busy, state_dbg
  );

  modport slave (
    input  load_en, opcode, operand_a, operand_b, auto_inc, write_pointer,
           read_en, read_pointer, flush,
    output load_rdy, instruction_word, instr_valid, wr_count, div_zero_err, busy, state_dbg
  );
endinterface

// File: rtl/instr_register_pipe.sv
// Pipelined instruction register: S1 captures the request, stage 2 computes the signed
// result and writes the entry; registered read-first reads; flush sweeps every entry clear.
module instr_register_pipe #(
  parameter int OP_WIDTH  = 32,
  parameter int DEPTH     = 32,
  parameter int RES_WIDTH = 2*OP_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  instr_register_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = 3 + 2*OP_WIDTH + RES_WIDTH + 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

  typedef enum logic [2:0] {
    OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD
  } opcode_t;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, SWEEP = 2'd2} state_t;

  state_t        state, next_state;
  logic          rdy_q;
  logic          sweep_en, sweep_last;
  logic [AW-1:0] sweep_idx;
  logic [AW-1:0] wr_count_q;

  logic                       s1_valid;
  opcode_t                    s1_opc;
  logic signed [OP_WIDTH-1:0] s1_a, s1_b;
  logic [AW-1:0]              s1_addr;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] word_q;
  logic         valid_q;
  logic         dz_err_q;

  logic          accept;
  logic [AW-1:0] wr_addr;
  logic          s1_addr_ok;
  logic          rd_addr_ok;

  logic signed [RES_WIDTH-1:0] a_ext, b_ext, res;
  logic                        dz;

  assign accept     = bus.load_en && rdy_q;
  assign wr_addr    = bus.auto_inc ? wr_count_q : bus.write_pointer;
  assign s1_addr_ok = {1'b0, s1_addr} < DEPTH_L;
  assign rd_addr_ok = {1'b0, bus.read_pointer} < DEPTH_L;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.flush) next_state = DRAIN;
      DRAIN:   next_state = SWEEP;
      SWEEP:   if (sweep_idx == LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    sweep_en      = (state == SWEEP);
    sweep_last    = (state == SWEEP) && (sweep_idx == LAST);
    bus.busy      = (state == DRAIN) || (state == SWEEP);
    bus.load_rdy  = rdy_q;
    bus.state_dbg = state;
  end

  // Ready is registered so it stays low through the reset cycle itself and rises
  // on the first edge seen with reset released.
  always_ff @(posedge clk) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= (next_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !sweep_en || sweep_last) sweep_idx <= '0;
    else                                     sweep_idx <= sweep_idx + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || sweep_last) begin
      wr_count_q <= '0;
    end else if (accept && bus.auto_inc) begin
      wr_count_q <= (wr_count_q == LAST) ? '0 : wr_count_q + AW'(1);
    end
  end

  // ---------------- Stage 1: request capture ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_opc   <= OP_ZERO;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_opc  <= opcode_t'(bus.opcode);
        s1_a    <= bus.operand_a;
        s1_b    <= bus.operand_b;
        s1_addr <= wr_addr;
      end
    end
  end

  // ---------------- Stage 2: signed arithmetic ----------------
  always_comb begin
    a_ext = {{(RES_WIDTH-OP_WIDTH){s1_a[OP_WIDTH-1]}}, s1_a};
    b_ext = {{(RES_WIDTH-OP_WIDTH){s1_b[OP_WIDTH-1]}}, s1_b};
    res   = '0;
    dz    = 1'b0;
    case (s1_opc)
      OP_ZERO:  res = '0;
      OP_PASSA: res = a_ext;
      OP_PASSB: res = b_ext;
      OP_ADD:   res = a_ext + b_ext;
      OP_SUB:   res = a_ext - b_ext;
      OP_MULT:  res = a_ext * b_ext;
      OP_DIV:   if (s1_b == '0) dz = 1'b1; else res = a_ext / b_ext;
      OP_MOD:   if (s1_b == '0) dz = 1'b1; else res = a_ext % b_ext;
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)              dz_err_q <= 1'b0;
    else if (s1_valid && dz)   dz_err_q <= 1'b1;
  end

  // Sweep and stage-2 writes never coincide: S1 is always empty once SWEEP starts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweep_en) begin
      mem[sweep_idx] <= '0;
    end else if (s1_valid && s1_addr_ok) begin
      mem[s1_addr] <= {s1_opc, s1_a, s1_b, res, dz};
    end
  end

  // ---------------- Registered read port (read-first) ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.read_en;
      if (bus.read_en) word_q <= rd_addr_ok ? mem[bus.read_pointer] : '0;
    end
  end

  assign bus.instruction_word = word_q;
  assign bus.instr_valid      = valid_q;
  assign bus.wr_count         = wr_count_q;
  assign bus.div_zero_err     = dz_err_q;
endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed plus randomized bench for instr_register_pipe against a transaction-level model.
module tb_instr_register_pipe;
  localparam int OP_WIDTH  = 32;
  localparam int DEPTH     = 6;
  localparam int RES_WIDTH = 64;
  localparam int AW        = 3;
  localparam int W         = 3 + 2*OP_WIDTH + RES_WIDTH + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  instr_register_pipe_if #(.OP_WIDTH(OP_WIDTH), .DEPTH(DEPTH), .RES_WIDTH(RES_WIDTH)) bus();

  instr_register_pipe #(.OP_WIDTH(OP_WIDTH), .DEPTH(DEPTH), .RES_WIDTH(RES_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Reference model state
  logic [W-1:0] m_mem [DEPTH];
  logic [W-1:0] m_word;
  logic [W-1:0] m_pend_word;
  bit           m_valid, m_pend, m_ready, m_dz;
  int           m_pend_addr, m_wr_count, m_phase;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_word(input logic [2:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r  = 0;
    bit     z  = 1'b0;
    case (opc)
      3'd1: r = sa;
      3'd2: r = sb;
      3'd3: r = sa + sb;
      3'd4: r = sa - sb;
      3'd5: r = sa * sb;
      3'd6: if (sb == 0) z = 1'b1; else r = sa / sb;
      3'd7: if (sb == 0) z = 1'b1; else r = sa % sb;
      default: r = 0;
    endcase
    return {opc, a, b, r, z};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($signed($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  // One clock: advance the model with the inputs currently driven, then compare.
  task automatic cycle();
    int rp;
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_pend = 0; m_wr_count = 0; m_dz = 0; m_phase = 0;
      m_ready = 0; m_word = '0; m_valid = 0;
    end else begin
      rp = int'(bus.read_pointer);
      m_valid = bus.read_en;
      if (bus.read_en) m_word = (rp < DEPTH) ? m_mem[rp] : '0;
      if (m_pend) begin
        if (m_pend_addr < DEPTH) m_mem[m_pend_addr] = m_pend_word;
        if (m_pend_word[0]) m_dz = 1;
      end
      m_pend = bus.load_en && m_ready;
      if (m_pend) begin
        m_pend_addr = bus.auto_inc ? m_wr_count : int'(bus.write_pointer);
        m_pend_word = ref_word(bus.opcode, bus.operand_a, bus.operand_b);
        if (bus.auto_inc) m_wr_count = (m_wr_count + 1) % DEPTH;
      end
      if (m_phase >= 2) begin
        m_mem[m_phase-2] = '0;
        if (m_phase == DEPTH + 1) begin
          m_phase = 0;
          m_wr_count = 0;
        end else begin
          m_phase++;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (bus.flush) begin
        m_phase = 1;
      end
      m_ready = (m_phase == 0);
    end
    @(posedge clk);
    #1;
    check("load_rdy", W'(bus.load_rdy), W'(m_ready));
    check("busy", W'(bus.busy), W'(m_phase != 0));
    check("wr_count", W'(bus.wr_count), W'(m_wr_count));
    check("div_zero_err", W'(bus.div_zero_err), W'(m_dz));
    check("instr_valid", W'(bus.instr_valid), W'(m_valid));
    check("instruction_word", bus.instruction_word, m_word);
  endtask

  task automatic quiet();
    bus.load_en = 0; bus.read_en = 0; bus.flush = 0; bus.auto_inc = 0;
  endtask

  task automatic load(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic ai, input int wp);
    bus.load_en = 1; bus.opcode = opc; bus.operand_a = a; bus.operand_b = b;
    bus.auto_inc = ai; bus.write_pointer = AW'(wp);
  endtask

  task automatic rd(input int p);
    bus.read_en = 1; bus.read_pointer = AW'(p);
  endtask

  task automatic read_all_zero(input string tag);
    quiet();
    for (int p = 0; p < 8; p++) begin
      rd(p);
      cycle();
      check(tag, bus.instruction_word, '0);
      check({tag, "_valid"}, W'(bus.instr_valid), W'(1'b1));
    end
    quiet();
  endtask

  initial begin
    bus.load_en = 0; bus.opcode = '0; bus.operand_a = '0; bus.operand_b = '0;
    bus.auto_inc = 0; bus.write_pointer = '0; bus.read_en = 0; bus.read_pointer = '0;
    bus.flush = 0;

    // Reset and post-reset state
    reset_n = 0;
    cycle(); cycle();
    check("reset_rdy", W'(bus.load_rdy), W'(1'b0));
    reset_n = 1;
    cycle();
    check("rdy_after_reset", W'(bus.load_rdy), W'(1'b1));
    read_all_zero("reset_word");

    // MULT to explicit address 5; same-edge read sees old contents
    load(3'd5, 32'hFFFF_FFFD, 32'd7, 0, 5);
    cycle();
    quiet(); rd(5);
    cycle();
    check("same_edge_old", bus.instruction_word, '0);
    cycle();
    check("mult_n2", bus.instruction_word, {3'd5, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0});

    // Signed divide/mod corners, back-to-back loads
    quiet();
    load(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);           cycle();
    load(3'd7, 32'hFFFF_FFF9, 32'd2, 0, 1);           cycle();
    load(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2);   cycle();
    load(3'd6, 32'd5, 32'd0, 0, 3);                   cycle();
    quiet(); cycle();
    rd(0); cycle();
    check("div_neg", bus.instruction_word, {3'd6, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    rd(1); cycle();
    check("mod_neg", bus.instruction_word, {3'd7, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    rd(2); cycle();
    check("div_minneg", bus.instruction_word, {3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0});
    rd(3); cycle();
    check("div_zero", bus.instruction_word, {3'd6, 32'd5, 32'd0, 64'd0, 1'b1});
    check("dz_sticky", W'(bus.div_zero_err), W'(1'b1));

    // auto_inc wraps DEPTH-1 -> 0
    quiet();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      load(3'd3, 32'(i), 32'(i), 1, 0);
      cycle();
      check("auto_wr_count", W'(bus.wr_count), W'(i % DEPTH));
    end
    quiet(); cycle();
    rd(0); cycle();
    check("auto_wrap", bus.instruction_word, {3'd3, 32'd7, 32'd7, 64'd14, 1'b0});

    // Out-of-range write discarded, out-of-range read returns zero
    quiet();
    load(3'd1, 32'd99, 32'd0, 0, 7); cycle();
    quiet(); cycle();
    rd(7); cycle();
    check("oor_read", bus.instruction_word, '0);
    check("oor_valid", W'(bus.instr_valid), W'(1'b1));

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bus.load_en       = ($urandom_range(0, 3) != 0);
      bus.opcode        = 3'($urandom_range(0, 7));
      bus.operand_a     = rand_op();
      bus.operand_b     = rand_op();
      bus.auto_inc      = 1'($urandom_range(0, 1));
      bus.write_pointer = AW'($urandom_range(0, 7));
      bus.read_en       = 1'($urandom_range(0, 1));
      bus.read_pointer  = AW'($urandom_range(0, 7));
      bus.flush         = ($urandom_range(0, 39) == 0);
      cycle();
    end
    quiet();
    for (int i = 0; i < DEPTH + 3; i++) cycle();

    // Load and flush on the same edge
    load(3'd1, 32'h1234, 32'd0, 0, 2);
    bus.flush = 1;
    cycle();
    check("flush_rdy0", W'(bus.load_rdy), W'(1'b0));
    quiet();
    for (int k = 1; k <= DEPTH; k++) begin
      rd(2);
      cycle();
      if (k == 2) check("flush_loaded", bus.instruction_word, {3'd1, 32'h1234, 32'd0, 64'h1234, 1'b0});
      check("flush_rdy_low", W'(bus.load_rdy), W'(1'b0));
    end
    quiet(); cycle();
    check("flush_rdy_back", W'(bus.load_rdy), W'(1'b1));
    check("flush_wr_count", W'(bus.wr_count), '0);
    read_all_zero("flush_word");

    // Reset in the middle of a sweep
    load(3'd3, 32'd1, 32'd2, 0, 4); cycle();
    quiet(); bus.flush = 1; cycle();
    quiet(); cycle(); cycle(); cycle();
    reset_n = 0; cycle();
    reset_n = 1; cycle();
    check("midsweep_rdy", W'(bus.load_rdy), W'(1'b1));
    check("midsweep_busy", W'(bus.busy), W'(1'b0));
    check("midsweep_dz", W'(bus.div_zero_err), W'(1'b0));
    read_all_zero("midsweep_word");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
